ram2_arbiter: RTL

Sequencer and arbiter for the RAM2 SRAM chip, which is shared by three requesters: the bootloader's init-write path, the EXE-stage load/store path and the IF-stage instruction fetch. It grants one requester at a time and latches that request's address and data at grant. It then drives the SRAM EN/OE/WE strobes with fixed multi-cycle read and write sequences and returns a one-cycle done pulse plus read data to the granted requester. It sits between the stall/hold logic and the physical RAM2 pins.

---
 rtl/ram2_arbiter.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/ram2_arbiter.sv
// RAM2 SRAM arbiter/sequencer for the init, EXE and IF requesters.
// Optional RAM2_RR_EN: alternate EXE/IF grants when both are pending.
module ram2_arbiter #(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              init_req,
  input  logic [15:0]       init_addr,
  input  logic [DATA_W-1:0] init_data,
  output logic              init_done,
  input  logic              exe_req,
  input  logic              exe_wr,
  input  logic [ADDR_W-1:0] exe_addr,
  input  logic [DATA_W-1:0] exe_wdata,
  output logic [DATA_W-1:0] exe_rdata,
  output logic              exe_done,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_done,
  output logic [ADDR_W-1:0] Ram2Addr,
  inout  wire  [DATA_W-1:0] Ram2Data,
  output logic              Ram2EN,
  output logic              Ram2OE,
  output logic              Ram2WE,
  output logic              busy,
  output logic [7:0]        status_out
);

  typedef enum logic [3:0] {
    IDLE = 4'd0, RD_A = 4'd1, RD_B = 4'd2, WR_A = 4'd3,
    WR_B = 4'd4, WR_C = 4'd5, DONE = 4'd6
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0, OWN_INIT = 2'd1, OWN_EXE = 2'd2, OWN_IF = 2'd3
  } owner_t;

  state_t              state_q, state_d;
  owner_t              owner_q, owner_d, grant_s;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   exe_rdata_q, exe_rdata_d, if_rdata_q, if_rdata_d;
  logic                en_q, en_d, oe_q, oe_d, we_q, we_d, drv_q, drv_d;
  logic                init_done_q, init_done_d, exe_done_q, exe_done_d;
  logic                if_done_q, if_done_d;
`ifdef RAM2_RR_EN
  logic                last_if_q, last_if_d;
`endif

  // Fixed-priority grant; the EXE/IF tie optionally alternates on last_if_q.
  always_comb begin
    grant_s = OWN_NONE;
    if (init_req) begin
      grant_s = OWN_INIT;
    end else if (exe_req && if_req) begin
`ifdef RAM2_RR_EN
      grant_s = last_if_q ? OWN_EXE : OWN_IF;
`else
      grant_s = OWN_EXE;
`endif
    end else if (exe_req) begin
      grant_s = OWN_EXE;
    end else if (if_req) begin
      grant_s = OWN_IF;
    end else begin
      grant_s = OWN_NONE;
    end
  end

  // Next state, grant-time latching and next values of the registered outputs.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    exe_rdata_d = exe_rdata_q;
    if_rdata_d  = if_rdata_q;
`ifdef RAM2_RR_EN
    last_if_d   = last_if_q;
`endif
    case (state_q)
      IDLE: begin
        case (grant_s)
          OWN_INIT: begin
            owner_d = OWN_INIT;
            addr_d  = {{(ADDR_W-16){1'b0}}, init_addr};
            wdata_d = init_data;
            state_d = WR_A;
          end
          OWN_EXE: begin
            owner_d = OWN_EXE;
            addr_d  = exe_addr;
            wdata_d = exe_wdata;
            state_d = exe_wr ? WR_A : RD_A;
`ifdef RAM2_RR_EN
            last_if_d = 1'b0;
`endif
          end
          OWN_IF: begin
            owner_d = OWN_IF;
            addr_d  = if_addr;
            state_d = RD_A;
`ifdef RAM2_RR_EN
            last_if_d = 1'b1;
`endif
          end
          default: state_d = IDLE;
        endcase
      end
      RD_A: state_d = RD_B;
      RD_B: begin
        state_d = DONE;
        if (owner_q == OWN_EXE) begin
          exe_rdata_d = Ram2Data;
        end else if (owner_q == OWN_IF) begin
          if_rdata_d = Ram2Data;
        end else begin
          exe_rdata_d = exe_rdata_q;
        end
      end
      WR_A: state_d = WR_B;
      WR_B: state_d = WR_C;
      WR_C: state_d = DONE;
      DONE: begin
        state_d = IDLE;
        owner_d = OWN_NONE;
      end
      default: begin
        state_d = IDLE;
        owner_d = OWN_NONE;
      end
    endcase

    // Strobes are registered from the next state so the pins never glitch.
    en_d        = !(state_d inside {RD_A, RD_B, WR_A, WR_B, WR_C});
    oe_d        = !(state_d inside {RD_A, RD_B});
    we_d        = (state_d != WR_B);
    drv_d       = (state_d inside {WR_A, WR_B, WR_C});
    init_done_d = (state_d == DONE) && (owner_d == OWN_INIT);
    exe_done_d  = (state_d == DONE) && (owner_d == OWN_EXE);
    if_done_d   = (state_d == DONE) && (owner_d == OWN_IF);
  end

  // State, latched request and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      owner_q     <= OWN_NONE;
      addr_q      <= {ADDR_W{1'b0}};
      wdata_q     <= {DATA_W{1'b0}};
      exe_rdata_q <= {DATA_W{1'b0}};
      if_rdata_q  <= {DATA_W{1'b0}};
      en_q        <= 1'b1;
      oe_q        <= 1'b1;
      we_q        <= 1'b1;
      drv_q       <= 1'b0;
      init_done_q <= 1'b0;
      exe_done_q  <= 1'b0;
      if_done_q   <= 1'b0;
`ifdef RAM2_RR_EN
      last_if_q   <= 1'b1;
`endif
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      exe_rdata_q <= exe_rdata_d;
      if_rdata_q  <= if_rdata_d;
      en_q        <= en_d;
      oe_q        <= oe_d;
      we_q        <= we_d;
      drv_q       <= drv_d;
      init_done_q <= init_done_d;
      exe_done_q  <= exe_done_d;
      if_done_q   <= if_done_d;
`ifdef RAM2_RR_EN
      last_if_q   <= last_if_d;
`endif
    end
  end

  assign Ram2Data   = drv_q ? wdata_q : {DATA_W{1'bz}};
  assign Ram2Addr   = addr_q;
  assign Ram2EN     = en_q;
  assign Ram2OE     = oe_q;
  assign Ram2WE     = we_q;
  assign init_done  = init_done_q;
  assign exe_done   = exe_done_q;
  assign if_done    = if_done_q;
  assign exe_rdata  = exe_rdata_q;
  assign if_rdata   = if_rdata_q;
  assign busy       = (state_q != IDLE);
  assign status_out = {owner_q, 2'b00, state_q};

endmodule
